// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 CALC steps plus a FIX step for sign correction, with single-edge MTHI/MTLO.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] a_raw;
    logic [31:0] b_mag;
    logic [31:0] work_hi;
    logic [31:0] work_lo;

    logic        signed_op;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod_neg;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // op[0]=0 selects the signed flavour of MULT/DIV
    assign signed_op = ~op[0];
    assign a_abs     = (signed_op && a[31]) ? 32'd0 - a : a;
    assign b_abs     = (signed_op && b[31]) ? 32'd0 - b : b;
    assign busy      = (state != IDLE);

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_mag} : 33'd0);
        div_shift = {work_hi, work_lo[31]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        // when div_ge the true difference is below b_mag, so 32 bits are exact
        div_sub   = div_shift[31:0] - b_mag;
        step_hi   = 32'd0;
        step_lo   = 32'd0;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[31:0];
            step_lo = {work_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], work_lo[31:1]};
        end

        prod_neg = 64'd0 - {work_hi, work_lo};
        quot_fix = (sign_a ^ sign_b) ? 32'd0 - work_lo : work_lo;
        rem_fix  = sign_a ? 32'd0 - work_hi : work_hi;
        res_hi   = work_hi;
        res_lo   = work_lo;
        if (!is_div) begin
            if (sign_a ^ sign_b) begin
                res_hi = prod_neg[63:32];
                res_lo = prod_neg[31:0];
            end
        end else if (b_mag == 32'd0) begin
            res_hi = a_raw;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_raw   <= 32'd0;
            b_mag   <= 32'd0;
            work_hi <= 32'd0;
            work_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            is_div  <= op[1];
                            sign_a  <= signed_op & a[31];
                            sign_b  <= signed_op & b[31];
                            a_raw   <= a;
                            b_mag   <= b_abs;
                            work_hi <= 32'd0;
                            work_lo <= a_abs;
                            cnt     <= 6'd0;
                            state   <= CALC;
                        end else if (!op[1]) begin
                            if (op[0]) begin
                                lo <= a;
                            end else begin
                                hi <= a;
                            end
                        end
                    end
                end
                CALC: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
